// File: rtl/axi_fifo_store.sv
// First-word-fall-through FIFO used as the storage stage behind the AXI-Lite FIFO bridge.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied to 0.
module axi_fifo_store #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_L  = AFULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = AEMPTY_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic                  wr_fire, rd_fire;

    // Extra pointer MSB is the wrap bit, so full and empty stay distinguishable.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AFULL_L);
    assign almost_empty = (count <= AEMPTY_L);
    assign rd_data      = mem[rd_ptr[ADDR_WIDTH-1:0]];

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the aresetn gate keeps writes during reset out of the array.
    always_ff @(posedge aclk) begin
        if (wr_fire && aresetn) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_set, unf_set;
    assign ovf_set = wr_en && full;
    // A read paired with a write into an empty FIFO loses nothing, so it is not an underflow.
    assign unf_set = rd_en && empty && !wr_en;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set || (overflow  && !clr_err);
            underflow <= unf_set || (underflow && !clr_err);
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_fifo_store.sv
// Directed self-checking bench for axi_fifo_store (default 32x16 configuration).
module tb_axi_fifo_store;
    localparam int DW = 32;
    localparam int AW = 4;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          full, almost_full;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic          empty, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          clr_err;

    int tests = 0;
    int fails = 0;

    axi_fifo_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .almost_full(almost_full), .rd_data(rd_data), .rd_en(rd_en), .empty(empty),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_status(input string tag, input int n);
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".full"}, 64'(full), 64'(n == 16));
        chk({tag, ".afull"}, 64'(almost_full), 64'(n >= 14));
        chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= 2));
    endtask

    logic [DW-1:0] d;

    initial begin
        aresetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        #12;
        chk_status("reset", 0);
        chk("reset.ovf", 64'(overflow), 64'(0));
        chk("reset.unf", 64'(underflow), 64'(0));
        aresetn = 1'b1;
        tick();
        chk_status("idle", 0);

        // three writes, then three pops in order
        wr_en = 1'b1; wr_data = 32'h11; tick();
        chk("w1.rd_data", 64'(rd_data), 64'h11);
        chk_status("w1", 1);
        wr_data = 32'h22; tick();
        wr_data = 32'h33; tick();
        wr_en = 1'b0;
        chk_status("w3", 3);
        rd_en = 1'b1;
        chk("pop1", 64'(rd_data), 64'h11); tick();
        chk("pop2", 64'(rd_data), 64'h22); tick();
        chk("pop3", 64'(rd_data), 64'h33); tick();
        rd_en = 1'b0;
        chk_status("drained", 0);

        // fill to depth, watching almost_full and full
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 32'h100 + 32'(i);
            tick();
            chk_status($sformatf("fill%0d", i + 1), i + 1);
        end
        wr_data = 32'hDEAD; tick();
        wr_en = 1'b0;
        chk_status("ovf_write", 16);
        chk("ovf_write.head", 64'(rd_data), 64'h100);
        chk("ovf_flag", 64'(overflow), 64'(ERR_ON));
        tick();
        chk("ovf_sticky", 64'(overflow), 64'(ERR_ON));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'(0));

        // simultaneous read/write on a full FIFO: pop happens, write dropped
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hBEEF; tick();
        wr_en = 1'b0;
        chk_status("full_rw", 15);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain%0d", i), 64'(rd_data), 64'(32'h100 + 32'(i)));
            tick();
        end
        rd_en = 1'b0;
        chk_status("drain_done", 0);

        // simultaneous read/write on an empty FIFO: write happens, read ignored
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hCAFE; tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_status("empty_rw", 1);
        chk("empty_rw.data", 64'(rd_data), 64'hCAFE);
        chk("empty_rw.unf", 64'(underflow), 64'(0));
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk_status("empty_rw.pop", 0);

        // 40 write/pop pairs streaming through, pointers wrap repeatedly
        wr_en = 1'b1; wr_data = 32'hA000_0000; tick();
        for (int i = 1; i < 40; i++) begin
            chk($sformatf("stream%0d.data", i - 1), 64'(rd_data), 64'(32'hA000_0000 + 32'(i - 1) * 3));
            wr_data = 32'hA000_0000 + 32'(i) * 3;
            rd_en = 1'b1;
            tick();
            chk($sformatf("stream%0d.count", i), 64'(count), 64'(1));
        end
        wr_en = 1'b0;
        chk("stream39.data", 64'(rd_data), 64'(32'hA000_0000 + 32'd39 * 3));
        tick(); rd_en = 1'b0;
        chk_status("stream_end", 0);

        // asynchronous reset mid-stream takes effect before the next edge
        wr_en = 1'b1; wr_data = 32'h5151; tick();
        wr_data = 32'h5252; tick();
        chk_status("pre_rst", 2);
        #2 aresetn = 1'b0;
        #1;
        chk_status("async_rst", 0);
        wr_en = 1'b0;
        #2 aresetn = 1'b1;
        tick();
        chk_status("post_rst", 0);

        // reads on empty are ignored
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rd_empty%0d", i), 64'(count), 64'(0));
        end
        rd_en = 1'b0;
        chk("unf_flag", 64'(underflow), 64'(ERR_ON));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("unf_clr", 64'(underflow), 64'(0));
        wr_en = 1'b1; wr_data = 32'h7777; tick(); wr_en = 1'b0;
        chk_status("after_unf", 1);
        chk("after_unf.data", 64'(rd_data), 64'h7777);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
